// File: rtl/mul_seq_ctrl.sv
// Sequencer for program 3: walks NUM_PAIRS signed 16x16 operand pairs in byte memory,
// multiplies each with an iterative shift-add unit and writes the 32-bit product back.
// Optional build macro ZERO_SKIP_EN: pairs with a zero operand skip MUL/FIX.
module mul_seq_ctrl #(
  parameter int NUM_PAIRS = 16,
  parameter int OP_BASE   = 0,
  parameter int RES_BASE  = 64,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic [3:0]    pair_idx
);

  typedef enum logic [2:0] {IDLE, RD, MUL, FIX, WR, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [7:0]  a_hi, a_lo, b_hi;
  logic [31:0] acc, mcand;
  logic [15:0] mplier;
  logic        neg;

  logic [15:0] a_w, b_w, a_abs, b_abs;
  logic [31:0] p_fix;
  logic [AW-1:0] op_addr_cur, op_addr_nxt, res_addr_cur;

  // B's low byte is taken straight off the read port in the last RD cycle
  assign a_w   = {a_hi, a_lo};
  assign b_w   = {b_hi, mem_rdata};
  assign a_abs = a_w[15] ? 16'(-a_w) : a_w;
  assign b_abs = b_w[15] ? 16'(-b_w) : b_w;
  assign p_fix = neg ? 32'(-acc) : acc;

  assign op_addr_cur  = AW'(OP_BASE)  + AW'({pair_idx, 2'b00});
  assign op_addr_nxt  = AW'(OP_BASE)  + AW'({pair_idx + 4'd1, 2'b00});
  assign res_addr_cur = AW'(RES_BASE) + AW'({pair_idx, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      pair_idx  <= '0;
      a_hi      <= '0;
      a_lo      <= '0;
      b_hi      <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= RD;
            busy     <= 1'b1;
            pair_idx <= '0;
            mem_addr <= AW'(OP_BASE);
            cnt      <= '0;
          end
        end
        RD: begin
          case (cnt)
            5'd1:    a_hi <= mem_rdata;
            5'd2:    a_lo <= mem_rdata;
            5'd3:    b_hi <= mem_rdata;
            default: ;
          endcase
          if (cnt < 5'd3) mem_addr <= mem_addr + AW'(1);
          if (cnt == 5'd4) begin
            cnt    <= '0;
            neg    <= a_w[15] ^ b_w[15];
            mcand  <= {16'b0, a_abs};
            mplier <= b_abs;
            acc    <= '0;
`ifdef ZERO_SKIP_EN
            if (a_w == 16'd0 || b_w == 16'd0) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_addr  <= res_addr_cur;
              mem_wdata <= '0;
            end else begin
              state <= MUL;
            end
`else
            state <= MUL;
`endif
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd15) state <= FIX;
        end
        FIX: begin
          // Load the signed product and stage the first (MSB) write
          acc       <= p_fix;
          mem_we    <= 1'b1;
          mem_addr  <= res_addr_cur;
          mem_wdata <= p_fix[31:24];
          cnt       <= '0;
          state     <= WR;
        end
        WR: begin
          if (cnt == 5'd3) begin
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            cnt       <= '0;
            if (pair_idx == 4'(NUM_PAIRS - 1)) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              mem_addr <= '0;
            end else begin
              state    <= RD;
              pair_idx <= pair_idx + 4'd1;
              mem_addr <= op_addr_nxt;
            end
          end else begin
            mem_addr  <= mem_addr + AW'(1);
            mem_wdata <= acc[23:16];
            acc       <= acc << 8;
            cnt       <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // op_addr_cur is kept for readability of the address map; RD walks from it
  logic unused_ok;
  assign unused_ok = ^op_addr_cur;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected writes are queued at load time and
// checked by a separate monitor; latency, handshake and memory contents checked directly.
module tb_mul_seq_ctrl;
  localparam int NP = 16;

  logic       clk = 1'b0, reset = 1'b1, req = 1'b0;
  logic       done, busy, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] pair_idx;

  logic [7:0]  mem [0:255];
  logic [15:0] va [NP];
  logic [15:0] vb [NP];
  logic [31:0] vp [NP];
  logic [15:0] exp_q [$];
  int          checks = 0, errors = 0, cyc = 0;

  mul_seq_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .pair_idx(pair_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        chk("write", {16'b0, mem_addr, mem_wdata}, {16'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic fill_table();
    va[0]  = 16'h0003; vb[0]  = 16'hFFFB; vp[0]  = 32'hFFFFFFF1;
    va[1]  = 16'h8000; vb[1]  = 16'h8000; vp[1]  = 32'h40000000;
    va[2]  = 16'h8000; vb[2]  = 16'h7FFF; vp[2]  = 32'hC0008000;
    va[3]  = 16'h7FFF; vb[3]  = 16'h7FFF; vp[3]  = 32'h3FFF0001;
    va[4]  = 16'hFFFF; vb[4]  = 16'hFFFF; vp[4]  = 32'h00000001;
    va[5]  = 16'hFFFF; vb[5]  = 16'h0001; vp[5]  = 32'hFFFFFFFF;
    va[6]  = 16'h0000; vb[6]  = 16'h04D2; vp[6]  = 32'h00000000;
    va[7]  = 16'h0064; vb[7]  = 16'h00C8; vp[7]  = 32'h00004E20;
    va[8]  = 16'hFF9C; vb[8]  = 16'h00C8; vp[8]  = 32'hFFFFB1E0;
    va[9]  = 16'h1234; vb[9]  = 16'h0010; vp[9]  = 32'h00012340;
    va[10] = 16'h0100; vb[10] = 16'h0100; vp[10] = 32'h00010000;
    va[11] = 16'hFF00; vb[11] = 16'h0100; vp[11] = 32'hFFFF0000;
    va[12] = 16'h8000; vb[12] = 16'h0001; vp[12] = 32'hFFFF8000;
    va[13] = 16'h8000; vb[13] = 16'hFFFF; vp[13] = 32'h00008000;
    va[14] = 16'h03E8; vb[14] = 16'hFC18; vp[14] = 32'hFFF0BDC0;
    va[15] = 16'h7FFF; vb[15] = 16'h8000; vp[15] = 32'hC0008000;
  endtask

  // Writes operands, poisons the result region and queues the expected writes
  task automatic load();
    logic [31:0] p;
    exp_q.delete();
    for (int k = 0; k < NP; k++) begin
      mem[4*k]   = va[k][15:8];
      mem[4*k+1] = va[k][7:0];
      mem[4*k+2] = vb[k][15:8];
      mem[4*k+3] = vb[k][7:0];
      for (int i = 0; i < 4; i++) mem[64+4*k+i] = 8'hAA;
      p = vp[k];
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({8'(64 + 4*k + i), p[31:24]});
        p = p << 8;
      end
    end
  endtask

  function automatic int exp_latency();
    int n = 0;
    for (int k = 0; k < NP; k++) begin
`ifdef ZERO_SKIP_EN
      n += (va[k] == 16'h0 || vb[k] == 16'h0) ? 9 : 26;
`else
      n += 26;
`endif
    end
    return n;
  endfunction

  task automatic check_mem(input int upto);
    for (int k = 0; k < NP; k++) begin
      chk("operand_intact", {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]}, {va[k], vb[k]});
      if (k < upto)
        chk("result_mem", {mem[64+4*k], mem[65+4*k], mem[66+4*k], mem[67+4*k]}, vp[k]);
    end
  endtask

  task automatic start_req(output int start);
    int t = 0;
    @(posedge clk); #1 req = 1'b1;
    @(negedge clk);
    while (!busy && t < 10) begin @(negedge clk); t++; end
    chk("busy_rise", {31'b0, busy}, 32'd1);
    start = cyc;
  endtask

  task automatic run_full(input string nm);
    int start, t;
    start_req(start);
    t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_latency"}, cyc - start, exp_latency());
    chk({nm, "_busy_low"}, {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk({nm, "_done_held"}, {30'b0, done, busy}, 32'd2);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({nm, "_done_drop"}, {31'b0, done}, 32'd0);
    chk({nm, "_queue_empty"}, exp_q.size(), 32'd0);
    check_mem(NP);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start, t;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {done, busy, mem_we, mem_addr, mem_wdata, pair_idx}, 32'd0);
    reset = 1'b0;

    // Single nonzero pair, everything else zero
    for (int k = 0; k < NP; k++) begin va[k] = 16'h0; vb[k] = 16'h0; vp[k] = 32'h0; end
    va[0] = 16'h0003; vb[0] = 16'hFFFB; vp[0] = 32'hFFFFFFF1;
    load();
    run_full("single");

    // Directed corner table, twice with a reset pulse between
    fill_table();
    for (int it = 0; it < 2; it++) begin
      pulse_reset();
      load();
      run_full("table");
    end

    // Abort in MUL of pair 5
    pulse_reset();
    load();
    start_req(start);
    t = 0;
    while (pair_idx != 4'd5 && t < 1000) begin @(negedge clk); t++; end
    chk("reach_pair5", {28'b0, pair_idx}, 32'd5);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("abort_outputs", {done, busy, mem_we, mem_addr, mem_wdata, pair_idx}, 32'd0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pending", exp_q.size(), 32'd44);
    check_mem(5);
    reset = 1'b0;
    load();
    run_full("after_abort");

    // First eight pairs with A=0 (cycle count depends on zero-skip build)
    for (int k = 0; k < 8; k++) begin va[k] = 16'h0; vp[k] = 32'h0; end
    vb[0] = 16'h1234; vb[6] = 16'h04D2;
    pulse_reset();
    load();
    run_full("zero_a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1, "timeout");
  end
endmodule
